seven_seg_scan_ctrl: RTL and testbench

//   Scan sequencer for the 4-digit multiplexed seven-segment display.

---
 rtl/seven_seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan sequencer with per-slot blanking and a double-buffered frame.
// Outputs decode registered state (no added latency); load_ready is low while one frame waits for the next frame boundary.
module seven_seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 4096,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [19:0] load_digits,
  output logic [1:0]  digit_sel,
  output logic [4:0]  digit_value,
  output logic [3:0]  anodes,
  output logic        frame_start
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    sel_nxt;
  logic [19:0]   front;
  logic [19:0]   back;
  logic          pending;
  logic          frame_end;
  logic          load_xfer;
  logic          swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      digit_sel <= 2'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      digit_sel <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = digit_sel;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        sel_nxt = 2'd0;
        if (enable) state_nxt = BLANK;
      end
      BLANK: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sel_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == BLANK_LAST) state_nxt = ON;
        end
      end
      ON: begin
        if (!enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sel_nxt   = 2'd0;
        end else if (cnt == SLOT_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
          sel_nxt   = digit_sel + 2'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sel_nxt   = 2'd0;
      end
    endcase
  end

  // The swap decision uses pending from before the edge, so a load accepted on
  // the boundary cycle waits a whole frame; IDLE has no frame to protect.
  assign frame_end = (state == ON) && (digit_sel == 2'd3) && (cnt == SLOT_LAST);
  assign load_xfer = load_valid && !pending;
  assign swap      = pending && (frame_end || (state == IDLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front   <= 20'h0;
      back    <= 20'h0;
      pending <= 1'b0;
    end else if (load_xfer) begin
      back    <= load_digits;
      pending <= 1'b1;
    end else if (swap) begin
      front   <= back;
      pending <= 1'b0;
    end
  end

  always_comb begin
    anodes      = 4'b1111;
    frame_start = (state == BLANK) && (cnt == '0) && (digit_sel == 2'd0);
    load_ready  = !pending;
    if (state == ON) anodes = ~(4'b0001 << digit_sel);
    case (digit_sel)
      2'd0:    digit_value = front[4:0];
      2'd1:    digit_value = front[9:5];
      2'd2:    digit_value = front[14:10];
      default: digit_value = front[19:15];
    endcase
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with an 8-cycle slot and 2-cycle blank.
module tb_seven_seg_scan_ctrl;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [19:0] load_digits;
  logic [1:0]  digit_sel;
  logic [4:0]  digit_value;
  logic [3:0]  anodes;
  logic        frame_start;

  seven_seg_scan_ctrl #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_digits (load_digits),
    .digit_sel   (digit_sel),
    .digit_value (digit_value),
    .anodes      (anodes),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] dat;
    int          acc_t;
  } load_rec_t;

  typedef struct {
    logic [19:0] frame;
    logic [4:0]  e0;
    logic [4:0]  e1;
    logic [4:0]  e2;
    logic [4:0]  e3;
  } vec_t;

  load_rec_t   frame_q[$];
  vec_t        vecs[4];
  logic [4:0]  exp_val[4];
  int          t;
  bit          scanning;
  bit          accepted;
  int          acc_t;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, wanted %0h", name, t, act, req);
    end
  endtask

  // Expected scan pattern is a pure function of the cycle index since enable.
  task automatic monitor();
    int         slot;
    int         pos;
    logic [3:0] exp_an;
    load_rec_t  r;
    slot = (t / SLOT) % 4;
    pos  = t % SLOT;
    if ((t % FRAME == 0) && (frame_q.size() > 0) && (frame_q[0].acc_t < t)) begin
      r = frame_q.pop_front();
      for (int n = 0; n < 4; n++) exp_val[n] = r.dat[5*n +: 5];
    end
    exp_an = (pos < BLANK) ? 4'b1111 : ~(4'b0001 << slot);
    chk("scan_anodes", anodes, exp_an);
    chk("scan_sel", digit_sel, slot);
    chk("scan_frame_start", frame_start, (t % FRAME) == 0);
    chk("scan_value", digit_value, exp_val[slot]);
  endtask

  task automatic step();
    load_rec_t r;
    accepted = 1'b0;
    if (scanning && load_valid && load_ready) begin
      accepted = 1'b1;
      acc_t    = t + 1;
      r.dat    = load_digits;
      r.acc_t  = t + 1;
      frame_q.push_back(r);
    end
    @(posedge clk);
    #1;
    t++;
    if (scanning) monitor();
  endtask

  task automatic run_to(input int target);
    while (t < target) step();
  endtask

  task automatic start_scan();
    enable   = 1'b1;
    t        = -1;
    scanning = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [4:0] prev_e0;
    n_chk = 0;
    n_fail = 0;
    t = 0;
    scanning = 1'b0;
    acc_t = 0;
    for (int n = 0; n < 4; n++) exp_val[n] = 5'h00;

    vecs[0] = '{20'h12345, 5'h05, 5'h1A, 5'h08, 5'h02};
    vecs[1] = '{20'hA5A5A, 5'h1A, 5'h12, 5'h16, 5'h14};
    vecs[2] = '{20'hF8000, 5'h00, 5'h00, 5'h00, 5'h1F};
    vecs[3] = '{20'hFFFFF, 5'h1F, 5'h1F, 5'h1F, 5'h1F};

    rst_n = 1'b0;
    enable = 1'b0;
    load_valid = 1'b0;
    load_digits = 20'h0;
    #3;
    chk("rst_anodes", anodes, 4'b1111);
    chk("rst_sel", digit_sel, 2'd0);
    chk("rst_value", digit_value, 5'h00);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_frame_start", frame_start, 1'b0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Free-running scan with an all-zero front frame, then a mid-frame load.
    start_scan();
    run_to(40);
    load_digits = {5'h13, 5'h02, 5'h01, 5'h00};
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t3_accept_t", acc_t, 41);
    chk("t3_ready_low", load_ready, 1'b0);

    // Second frame held against back-pressure until the boundary frees the buffer.
    load_digits = {5'h1F, 5'h0A, 5'h05, 5'h1B};
    load_valid = 1'b1;
    accepted = 1'b0;
    while (!accepted && t < 200) begin
      step();
      if (!accepted) chk("t4_ready", load_ready, t == 64);
    end
    load_valid = 1'b0;
    chk("t4_accept_t", acc_t, 65);
    chk("t4_ready_low", load_ready, 1'b0);
    run_to(90);
    chk("t3_slot3_dp", digit_value, 5'h13);

    // Load on the boundary cycle of frame 3.
    run_to(127);
    load_digits = {5'h0C, 5'h0B, 5'h0A, 5'h09};
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t5_accept_t", acc_t, 128);
    chk("t5_old_front", digit_value, 5'h1B);
    run_to(160);
    chk("t5_new_front", digit_value, 5'h09);

    // Disable mid-slot on digit 2, then restart.
    run_to(181);
    chk("t6_sel_before", digit_sel, 2'd2);
    enable = 1'b0;
    scanning = 1'b0;
    step();
    chk("t6_anodes_off", anodes, 4'b1111);
    chk("t6_sel_zero", digit_sel, 2'd0);
    chk("t6_no_fstart", frame_start, 1'b0);
    step();
    chk("t6_idle_anodes", anodes, 4'b1111);
    start_scan();
    chk("t6_restart_fstart", frame_start, 1'b1);
    run_to(10);
    chk("t6_digit1", digit_value, 5'h0A);

    // Asynchronous reset mid-scan with a frame pending.
    load_digits = 20'hFFFFF;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t1_pending", load_ready, 1'b0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t1_anodes", anodes, 4'b1111);
    chk("t1_sel", digit_sel, 2'd0);
    chk("t1_value", digit_value, 5'h00);
    chk("t1_ready", load_ready, 1'b1);
    chk("t1_frame_start", frame_start, 1'b0);
    scanning = 1'b0;
    enable = 1'b0;
    frame_q.delete();
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_discard_value", digit_value, 5'h00);
      chk("t1_discard_ready", load_ready, 1'b1);
    end

    // Table: load each frame while idle, then scan one full frame of it.
    prev_e0 = 5'h00;
    for (int i = 0; i < 4; i++) begin
      load_digits = vecs[i].frame;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      chk("tbl_ready_low", load_ready, 1'b0);
      chk("tbl_not_yet", digit_value, prev_e0);
      step();
      chk("tbl_ready_high", load_ready, 1'b1);
      chk("tbl_idle_value", digit_value, vecs[i].e0);
      exp_val[0] = vecs[i].e0;
      exp_val[1] = vecs[i].e1;
      exp_val[2] = vecs[i].e2;
      exp_val[3] = vecs[i].e3;
      start_scan();
      run_to(FRAME - 1);
      enable = 1'b0;
      scanning = 1'b0;
      step();
      chk("tbl_stop_anodes", anodes, 4'b1111);
      prev_e0 = vecs[i].e0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
